serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Bit-serial adder/subtractor that feeds the team's existing single-bit full-adder cell one operand bit per clock, LSB first, and holds the carry in a flip-flop between bits. It sits directly upstream of, and wraps, one fulladder instance. It trades latency for area when adding or subtracting two WIDTH-bit words. Operands are loaded on a start pulse, and the result is presented with a done pulse, carry-out and signed overflow.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
Start  input  1  request; sampled only in IDLE
Sub  input  1  0 = A+B, 1 = A-B; captured with Start
A  input  WIDTH  operand A; captured with Start
B  input  WIDTH  operand B; captured with Start
Busy  output  1  high whenever state != IDLE
Done  output  1  one-cycle pulse, result valid
Result  output  WIDTH  sum/difference, held until next accepted Start
Cout  output  1  final carry; for Sub=1, 1 = no borrow (A >= B unsigned)
Overflow  output  1  two's-complement overflow, carry into MSB XOR carry out of MSB

Behaviour:
- Reset:
  - Sampled low on an edge: state=IDLE; Busy=0, Done=0, Result=0, Cout=0, Overflow=0; shift registers, carry FF and bit counter cleared.
  - Reset overrides all other activity, including mid-RUN; no partial result survives.
- Initial FSM states:
  - IDLE: Busy=0. Start=1 on edge k loads opA=A and opB=B XOR {WIDTH{Sub}}, carry=Sub, cnt=0, then goes to RUN.
  - Loading at edge k clears Result, Cout and Overflow.
- RUN, edges k+1 .. k+WIDTH:
  - The fulladder gets A=opA[0], B=opB[0], Cin=carry.
  - Sum shifts into Result from the MSB side (Result <= {Sum, Result[WIDTH-1:1]}).
  - carry<=Cout; opA and opB shift right; cnt++.
  - On the bit with cnt==WIDTH-1, carry-in is saved as cmsb.
- End of RUN, edge k+WIDTH:
  - Last bit is processed; state goes to DONE.
  - Done registered high; Cout=final carry; Overflow=cmsb XOR final carry.
- DONE: lasts one cycle. Next edge: state=IDLE, Done=0. Result, Cout and Overflow hold.
- Latency: Done is high in the cycle following edge k+WIDTH, i.e. WIDTH edges after the Start-accept edge. Throughput is one operation per WIDTH+2 cycles.
- Start handling:
  - Ignored in RUN and DONE (no queuing).
  - A, B and Sub changes after the accept edge have no effect.
- Width rules: all arithmetic is modulo 2^WIDTH. cnt is $clog2(WIDTH)+1 bits and never wraps within an operation.
- Simultaneous Start and rst_n=0: reset wins, Start is dropped.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DONE}
  - the default WIDTH constant
  - a function computing the counter width from WIDTH
- Sub-module: one instance of the existing fulladder cell (combinational, bit datapath). All sequencing, shifting and carry storage live in serial_addsub.

Test Plan:
- WIDTH=8, A=0x35, B=0x1A, Sub=0, Start 1 cycle -> Busy 1 from next cycle; Done exactly 8 edges after accept; Result=0x4F, Cout=0, Overflow=0.
- A=0x7F, B=0x01, Sub=0 -> Result=0x80, Cout=0, Overflow=1.
- A=0x10, B=0x20, Sub=1 -> Result=0xF0, Cout=0 (borrow), Overflow=0.
- A=0xFF, B=0x01, Sub=0 -> Result=0x00, Cout=1, Overflow=0. Then A=0x80, B=0x01, Sub=1 -> Result=0x7F, Cout=1, Overflow=1.
- Start held high and A/B toggled throughout RUN -> single operation only; result matches operands captured at the accept edge; Done pulses once; a new op starts only from IDLE.
- rst_n=0 for one edge at the 3rd RUN cycle -> next cycle Busy=0, Done=0, Result=0, Cout=0, Overflow=0. A following Start with A=0x01, B=0x01, Sub=0 -> Result=0x02.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit counter is one bit wider than needed to index WIDTH, so it never wraps mid-operation.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_addsub_fulladder.sv
// Single-bit full-adder cell, purely combinational.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one operand bit per clock through a fulladder, LSB first,
// with the carry held in a flip-flop between bits.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    fulladder u_fa (
        .A    (opa[0]),
        .B    (opb[0]),
        .Cin  (carry),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    assign Busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            Done     <= 1'b0;
            Result   <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        opa      <= A;
                        opb      <= B ^ {WIDTH{Sub}};
                        carry    <= Sub;
                        cnt      <= '0;
                        Result   <= '0;
                        Cout     <= 1'b0;
                        Overflow <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    Result <= {fa_sum, Result[WIDTH-1:1]};
                    carry  <= fa_cout;
                    opa    <= opa >> 1;
                    opb    <= opb >> 1;
                    cnt    <= cnt + 1'b1;
                    // The MSB's carry-in is still in 'carry' on the last bit, so overflow
                    // is formed here directly instead of via a separate saved copy.
                    if (cnt == CW'(WIDTH - 1)) begin
                        Cout     <= fa_cout;
                        Overflow <= carry ^ fa_cout;
                        Done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: stimulus pushes expectations, monitor checks on Done.
module tb_serial_addsub;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         Start;
    logic         Sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         Cout;
    logic         Overflow;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   n_done   = 0;
    int   n_pushed = 0;
    logic prev_done = 1'b0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Start    (Start),
        .Sub      (Sub),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .Cout     (Cout),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every Done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && Done === 1'b1) begin
            n_done++;
            chk("done_single_cycle", int'(prev_done), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result",   int'(Result),   int'(e.r));
                chk("cout",     int'(Cout),     int'(e.c));
                chk("overflow", int'(Overflow), int'(e.v));
                chk("latency",  cyc - e.acc,    int'(W));
            end
        end
        prev_done = Done;
    end

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
        chk("idle_busy", int'(Busy), 0);
        chk("idle_done", int'(Done), 0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] r, input logic c, input logic v, input bit hold);
        exp_t e;
        @(negedge clk);
        A = a; B = b; Sub = sub; Start = 1'b1;
        @(posedge clk);
        #1;
        e.r = r; e.c = c; e.v = v; e.acc = cyc;
        exp_q.push_back(e);
        n_pushed++;
        if (!hold) Start = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", int'(Busy), 1);
        if (hold) begin
            // Keep Start high and scramble operands through all of RUN and DONE.
            A = $urandom; B = $urandom; Sub = ~Sub;
            repeat (W) begin
                @(negedge clk);
                A = $urandom; B = $urandom; Sub = ~Sub;
            end
            Start = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; Start = 1'b0; Sub = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy",     int'(Busy),     0);
        chk("rst_done",     int'(Done),     0);
        chk("rst_result",   int'(Result),   0);
        chk("rst_cout",     int'(Cout),     0);
        chk("rst_overflow", int'(Overflow), 0);

        run_op(8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op(8'h5A, 8'hA5, 1'b1, 8'hB5, 1'b0, 1'b1, 1'b0);

        // Result must hold after Done while idle.
        repeat (3) @(negedge clk);
        chk("result_hold", int'(Result), 8'hB5);

        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        repeat (W + 4) @(negedge clk);
        chk("held_start_single_op", int'(Busy), 0);
        chk("done_count", n_done, n_pushed);

        // Reset on the third RUN edge aborts the operation.
        @(negedge clk);
        A = 8'h35; B = 8'h1A; Sub = 1'b0; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy",     int'(Busy),     0);
        chk("abort_done",     int'(Done),     0);
        chk("abort_result",   int'(Result),   0);
        chk("abort_cout",     int'(Cout),     0);
        chk("abort_overflow", int'(Overflow), 0);
        repeat (W + 2) @(negedge clk);
        chk("abort_no_done", n_done, n_pushed);

        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        chk("final_done_count", n_done, n_pushed);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
